// File: rtl/reset_seq_pkg.sv
// Shared types for the reset sequencer: FSM state encoding and reset-cause codes.
// Latency: n/a (types and a compile-time helper only).
// Backpressure: n/a.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD       = 2'd0,
        REL_BUS    = 2'd1,
        REL_PERIPH = 2'd2,
        RUN        = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_POR  = 2'b00,
        CAUSE_SOFT = 2'b01,
        CAUSE_WDT  = 2'b10
    } cause_t;

    // Width of the shared stretch/gap counter: enough to hold max(a,b)-1.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Software-side handshake and reset fan-out bundle of the reset sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; soft_rst_req is a level, soft_rst_ack a one-cycle pulse.
// Ports: master = requester/consumer side, slave = reset_sequencer.
interface reset_sequencer_if;

    logic       soft_rst_req;
    logic       soft_rst_ack;
    logic       wdt_en;
    logic       wdt_kick;
    logic       bus_reset;
    logic       periph_reset;
    logic       cpu_reset;
    logic       sys_ready;
    logic [1:0] reset_cause;

    modport master (
        output soft_rst_req, wdt_en, wdt_kick,
        input  soft_rst_ack, bus_reset, periph_reset, cpu_reset, sys_ready, reset_cause
    );

    modport slave (
        input  soft_rst_req, wdt_en, wdt_kick,
        output soft_rst_ack, bus_reset, periph_reset, cpu_reset, sys_ready, reset_cause
    );

endinterface

// File: rtl/reset_seq_wdt.sv
// Watchdog counter for the reset sequencer; flags expiry when the count reaches all-ones.
// Latency: expire is combinational on the cycle the counter would reach all-ones.
// Backpressure: none; a kick in the expiry cycle suppresses the expiry.
// Ports: clk, reset (sync, active-high), run (sequencer in RUN), wdt_en, wdt_kick -> expire.
module reset_seq_wdt #(
    parameter int WDT_WIDTH = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic wdt_en,
    input  logic wdt_kick,
    output logic expire
);

    logic [WDT_WIDTH-1:0] wcnt;
    logic [WDT_WIDTH-1:0] wcnt_nxt;

    // Count only while enabled in RUN; kick, disable or leaving RUN all clear it.
    always_comb begin
        wcnt_nxt = '0;
        if (run && wdt_en && !wdt_kick) begin
            wcnt_nxt = wcnt + 1'b1;
        end
    end

    assign expire = &wcnt_nxt;

    always_ff @(posedge clk) begin
        if (reset || expire) begin
            wcnt <= '0;
        end else begin
            wcnt <= wcnt_nxt;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Stretches the chip reset, then releases bus, peripheral and CPU resets in order; soft reset and optional watchdog.
// Latency: bus/periph/cpu release STRETCH_CYCLES, +STAGE_GAP, +2*STAGE_GAP edges after reset drops; all outputs registered.
// Backpressure: soft_rst_req honoured only in RUN, acked with a single-cycle pulse; elsewhere it is ignored.
// Ports: clk, reset (sync, active-high), sif (reset_sequencer_if.slave).
// Build option: define RST_SEQ_WDT_EN to build the watchdog (reset_seq_wdt); otherwise wdt_en/wdt_kick are ignored.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int STRETCH_CYCLES = 16,
    parameter int STAGE_GAP      = 8,
    parameter int WDT_WIDTH      = 16
) (
    input  logic                clk,
    input  logic                reset,
    reset_sequencer_if.slave    sif
);

    localparam int CW = cnt_width(STRETCH_CYCLES, STAGE_GAP);
    localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST     = CW'(STAGE_GAP - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          bus_q, bus_nxt;
    logic          periph_q, periph_nxt;
    logic          cpu_q, cpu_nxt;
    logic          ready_q, ready_nxt;
    logic          ack_q, ack_nxt;
    cause_t        cause_q, cause_nxt;
    logic          wdt_expire;

`ifdef RST_SEQ_WDT_EN
    reset_seq_wdt #(
        .WDT_WIDTH (WDT_WIDTH)
    ) u_wdt (
        .clk      (clk),
        .reset    (reset),
        .run      (state == RUN),
        .wdt_en   (sif.wdt_en),
        .wdt_kick (sif.wdt_kick),
        .expire   (wdt_expire)
    );
`else
    logic wdt_unused;
    assign wdt_expire = 1'b0;
    assign wdt_unused = sif.wdt_en ^ sif.wdt_kick ^ WDT_WIDTH[0];
`endif

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        bus_nxt    = bus_q;
        periph_nxt = periph_q;
        cpu_nxt    = cpu_q;
        ready_nxt  = ready_q;
        ack_nxt    = 1'b0;
        cause_nxt  = cause_q;
        case (state)
            HOLD: begin
                if (cnt == STRETCH_LAST) begin
                    state_nxt = REL_BUS;
                    cnt_nxt   = '0;
                    bus_nxt   = 1'b0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            REL_BUS: begin
                if (cnt == GAP_LAST) begin
                    state_nxt  = REL_PERIPH;
                    cnt_nxt    = '0;
                    periph_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            REL_PERIPH: begin
                if (cnt == GAP_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                    cpu_nxt   = 1'b0;
                    ready_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RUN: begin
                // Soft request outranks a coincident watchdog expiry.
                if (sif.soft_rst_req || wdt_expire) begin
                    state_nxt  = HOLD;
                    cnt_nxt    = '0;
                    bus_nxt    = 1'b1;
                    periph_nxt = 1'b1;
                    cpu_nxt    = 1'b1;
                    ready_nxt  = 1'b0;
                    ack_nxt    = sif.soft_rst_req;
                    cause_nxt  = sif.soft_rst_req ? CAUSE_SOFT : CAUSE_WDT;
                end
            end
            default: begin
                state_nxt = HOLD;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= HOLD;
            cnt      <= '0;
            bus_q    <= 1'b1;
            periph_q <= 1'b1;
            cpu_q    <= 1'b1;
            ready_q  <= 1'b0;
            ack_q    <= 1'b0;
            cause_q  <= CAUSE_POR;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            bus_q    <= bus_nxt;
            periph_q <= periph_nxt;
            cpu_q    <= cpu_nxt;
            ready_q  <= ready_nxt;
            ack_q    <= ack_nxt;
            cause_q  <= cause_nxt;
        end
    end

    assign sif.bus_reset    = bus_q;
    assign sif.periph_reset = periph_q;
    assign sif.cpu_reset    = cpu_q;
    assign sif.sys_ready    = ready_q;
    assign sif.soft_rst_ack = ack_q;
    assign sif.reset_cause  = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: expected output changes (edge number + value) are queued by stimulus,
// and a negedge monitor pops one entry each time the output vector changes.
// Output vector layout: {bus_reset, periph_reset, cpu_reset, sys_ready, soft_rst_ack, reset_cause[1:0]}.
module tb_reset_sequencer;

    localparam int S = 16;
    localparam int G = 8;

    typedef struct {
        int         at;
        logic [6:0] vec;
    } ev_t;

    logic clk;
    logic reset;
    int   g;
    int   checks;
    int   failures;
    ev_t  exp_q[$];

    reset_sequencer_if sif();

    reset_sequencer #(
        .STRETCH_CYCLES (S),
        .STAGE_GAP      (G),
        .WDT_WIDTH      (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sif   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial g = 0;
    always @(posedge clk) g <= g + 1;

    // Return just after rising edge n, so inputs set now are sampled at edge n+1.
    task automatic goto(input int n);
        while (g < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int at, input logic b, input logic p, input logic c,
                        input logic r, input logic a, input logic [1:0] cause);
        ev_t e;
        e.at  = at;
        e.vec = {b, p, c, r, a, cause};
        exp_q.push_back(e);
    endtask

    // Release schedule counted from base, where edge base+1 is the first edge with reset deasserted.
    task automatic push_release(input int base, input logic [1:0] cause);
        push(base + S,         1'b0, 1'b1, 1'b1, 1'b0, 1'b0, cause);
        push(base + S + G,     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, cause);
        push(base + S + 2 * G, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, cause);
    endtask

    // Monitor: every change of the output vector must match the next queued event, value and edge.
    logic [6:0] prev;
    logic [6:0] cur;
    bit         started;
    int         ev_idx;
    initial begin
        started = 1'b0;
        ev_idx  = 0;
        prev    = '0;
    end
    always @(negedge clk) begin
        if (g >= 1) begin
            cur = {sif.bus_reset, sif.periph_reset, sif.cpu_reset, sif.sys_ready,
                   sif.soft_rst_ack, sif.reset_cause};
            if (!started || cur !== prev) begin
                ev_t e;
                started = 1'b1;
                prev    = cur;
                checks++;
                ev_idx++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change ev%0d edge=%0d got=%b required=no change", ev_idx, g, cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e.vec || g != e.at) begin
                        failures++;
                        $display("FAIL output_event ev%0d got edge=%0d vec=%b required edge=%0d vec=%b",
                                 ev_idx, g, cur, e.at, e.vec);
                    end
                end
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset            = 1'b1;
        sif.soft_rst_req = 1'b0;
        sif.wdt_en       = 1'b0;
        sif.wdt_kick     = 1'b0;

        // Power-on: reset values, then release schedule from edge 5.
        push(1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
        goto(5);
        reset = 1'b0;
        push_release(5, 2'b00);

        // Soft reset pulse sampled at edge 45 (40 edges after release).
        goto(44);
        sif.soft_rst_req = 1'b1;
        push(45, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01);
        push(46, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01);
        push_release(45, 2'b01);
        goto(45);
        sif.soft_rst_req = 1'b0;

        // Request held through REL_BUS/REL_PERIPH: only one ack, one edge after RUN (entered at 77).
        goto(63);
        sif.soft_rst_req = 1'b1;
        push(78, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01);
        push(79, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01);
        push(94, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01);
        goto(80);
        sif.soft_rst_req = 1'b0;

        // Reset asserted during REL_BUS (sampled at edge 98); cause returns to POR.
        goto(97);
        reset = 1'b1;
        push(98, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
        goto(100);
        reset = 1'b0;
        push_release(100, 2'b00);

        // Watchdog enabled from the RUN entry at edge 132.
        goto(132);
        sif.wdt_en = 1'b1;
`ifdef RST_SEQ_WDT_EN
        push(147, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10);
        push_release(147, 2'b10);
`endif
        // Kicks sampled at edges 185,195,205,215 keep the count below expiry.
        for (int k = 0; k < 4; k++) begin
            goto(184 + 10 * k);
            sif.wdt_kick = 1'b1;
            goto(185 + 10 * k);
            sif.wdt_kick = 1'b0;
        end
        // Kick exactly on the would-be expiry edge 230.
        goto(229);
        sif.wdt_kick = 1'b1;
        goto(230);
        sif.wdt_kick = 1'b0;
        // Soft request on the expiry edge 245: soft wins, ack and cause 01.
        goto(244);
        sif.soft_rst_req = 1'b1;
        push(245, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01);
        push(246, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01);
        push_release(245, 2'b01);
        goto(245);
        sif.soft_rst_req = 1'b0;
        goto(277);
        sif.wdt_en = 1'b0;

        goto(300);
        #1;
        while (exp_q.size() > 0) begin
            ev_t e;
            e = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_event got=no change required edge=%0d vec=%b", e.at, e.vec);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Sequences the system reset released by the clock generator. It takes the chip-level reset once the clock is stable, stretches it, and releases the bus, peripheral and CPU resets in a fixed order with programmable gaps. It also provides a software reset request handshake and an optional watchdog. It sits directly downstream of the clock generator and drives the reset inputs of every synchronous subsystem on `clk`.

## Interface
- `STRETCH_CYCLES`, 16: cycles all resets stay asserted after `reset` deasserts (≥2)
- `STAGE_GAP`, 8: cycles between successive stage releases (≥1)
- `WDT_WIDTH`, 16: watchdog counter width
- `clk` input 1: system clock (CLK0 of the clock generator)
- `reset` input 1: synchronous, active-high reset, driven from `chip_reset`
- `soft_rst_req` input 1: level request for a software reset, sampled in RUN only
- `wdt_en` input 1: watchdog enable
- `wdt_kick` input 1: single-cycle watchdog clear
- `bus_reset` output 1: active-high, released first
- `periph_reset` output 1: active-high, released second
- `cpu_reset` output 1: active-high, released last
- `sys_ready` output 1: high only in RUN
- `soft_rst_ack` output 1: one-cycle pulse accepting a soft reset
- `reset_cause` output 2: 00 POR, 01 SOFT, 10 WDT

## Operation
- **FSM states:** HOLD, REL_BUS, REL_PERIPH, RUN. All outputs are registered.
- **While `reset`=1:**
  - State is HOLD and `cnt`=0.
  - `bus_reset`, `periph_reset` and `cpu_reset` are all 1.
  - `sys_ready`=0 and `soft_rst_ack`=0.
  - `reset_cause`=00.
  - The watchdog counter is 0.
- **HOLD:** `cnt` increments each cycle. When `cnt`=STRETCH_CYCLES-1, the FSM moves to REL_BUS, `cnt` is cleared and `bus_reset` goes to 0.
- **REL_BUS:** when `cnt`=STAGE_GAP-1, the FSM moves to REL_PERIPH, `cnt` is cleared and `periph_reset` goes to 0.
- **REL_PERIPH:** when `cnt`=STAGE_GAP-1, the FSM moves to RUN, `cpu_reset` goes to 0 and `sys_ready` goes to 1.
- **RUN, soft reset:** `soft_rst_req`=1 causes, on the next edge:
  - `soft_rst_ack`=1 for one cycle;
  - all three resets go to 1 and `sys_ready` goes to 0;
  - state goes to HOLD with `cnt`=0;
  - `reset_cause`=01.
- **`soft_rst_req` outside RUN:** ignored; no ack is generated.
- **`reset_cause`:** holds its value across soft and watchdog sequences. Only `reset` returns it to 00.
- **`reset` asserted mid-sequence or in RUN:** immediate return to the reset values on the next edge. Any sequence in progress is abandoned.
- **Counter width:** `cnt` is $clog2(max(STRETCH_CYCLES, STAGE_GAP)) bits and never wraps; the FSM clears it before overflow.

## Timing
- Edge numbering: edge 1 is the first rising edge at which `reset` is sampled 0.
- `bus_reset` falls after edge STRETCH_CYCLES.
- `periph_reset` falls after edge STRETCH_CYCLES+STAGE_GAP.
- `cpu_reset` falls and `sys_ready` rises after edge STRETCH_CYCLES+2·STAGE_GAP.
- Soft reset: request sampled at edge N; ack and resets asserted after edge N; release follows the same schedule counted from edge N+1.
- The ack is a single cycle even if `soft_rst_req` is held. A held request re-triggers only once RUN is reached again.

## Configuration
- **`RST_SEQ_WDT_EN` defined:**
  - A WDT_WIDTH-bit counter increments each cycle in RUN while `wdt_en`=1.
  - It is cleared by `wdt_kick`, by `wdt_en`=0, and in any state other than RUN.
  - When it reaches all-ones it triggers the same reassertion as a soft reset, with `reset_cause`=10 and no ack.
  - `wdt_kick` on the expiry cycle wins: counter cleared, no reset.
  - `soft_rst_req` and expiry in the same cycle: soft wins, ack issued, cause 01.
- **Not defined:** no watchdog logic is built. `wdt_en` and `wdt_kick` are ignored, and `reset_cause` is never 10. The port list is unchanged.

## Structure
- **Package `reset_seq_pkg`:**
  - state encoding: HOLD 2'd0, REL_BUS 2'd1, REL_PERIPH 2'd2, RUN 2'd3;
  - cause codes: CAUSE_POR, CAUSE_SOFT, CAUSE_WDT.
- **Sub-module `reset_seq_wdt`:** the watchdog counter with an `expire` output. It is instantiated only under `RST_SEQ_WDT_EN`.

## Test plan
- **Power-on:** `reset`=1 for 5 cycles, then 0, with STRETCH=16 and GAP=8 → `bus_reset` falls after edge 16, `periph_reset` after edge 24, `cpu_reset` and `sys_ready` after edge 32; `reset_cause`=00.
- **Soft reset:** in RUN, pulse `soft_rst_req` at edge 40 → ack high exactly one cycle, all resets 1 after edge 40, `sys_ready` back after edge 72, `reset_cause`=01.
- **Soft request in sequence:** hold `soft_rst_req` during REL_BUS → no ack and the release schedule is unchanged; ack arrives one edge after RUN is entered.
- **Reset mid-sequence:** assert `reset` at edge 20 (REL_BUS) → all resets 1 on the next edge, `reset_cause`=00; the full schedule restarts on release.
- **Watchdog expiry (`RST_SEQ_WDT_EN`, WDT_WIDTH=4):** `wdt_en`=1 with no kick → reset reasserted 15 cycles into RUN, `reset_cause`=10, no ack.
- **Watchdog kick and priority (`RST_SEQ_WDT_EN`, WDT_WIDTH=4):** kick every 10 cycles → never expires. Kick on the expiry cycle → no reset. Soft request on the expiry cycle → cause 01 with ack.
